// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bus sequencer: engine commands, FSM states and the latched request.
package i2c_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned N_CLI  = 2;
   localparam logic        ACK    = 1'b0;

   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_STOP  = 2'd3
   } eng_cmd_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_ADDR   = 3'd2,
      S_DATA   = 3'd3,
      S_STOP   = 3'd4,
      S_FINISH = 3'd5
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw;
      logic [DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/i2c_bus_sequencer_if.sv
// Client request bus plus I2C byte-engine command bus; master = sequencer side.
interface i2c_bus_sequencer_if;
   import i2c_pkg::*;

   logic [N_CLI-1:0]  Req;
   logic [ADDR_W-1:0] Addr0;
   logic [ADDR_W-1:0] Addr1;
   logic [N_CLI-1:0]  RW;
   logic [DATA_W-1:0] WrData0;
   logic [DATA_W-1:0] WrData1;
   logic [N_CLI-1:0]  Grant;
   logic [N_CLI-1:0]  ReqDone;
   logic              Nack;
   logic              Error;
   logic [DATA_W-1:0] RdData;
   eng_cmd_e          EngCmd;
   logic              EngGo;
   logic [DATA_W-1:0] EngTxData;
   logic              EngDone;
   logic              EngAck;
   logic [DATA_W-1:0] EngRxData;
   logic              EngAbort;

   modport master (
      input  Req, Addr0, Addr1, RW, WrData0, WrData1, EngDone, EngAck, EngRxData,
      output Grant, ReqDone, Nack, Error, RdData, EngCmd, EngGo, EngTxData, EngAbort
   );

   modport slave (
      output Req, Addr0, Addr1, RW, WrData0, WrData1, EngDone, EngAck, EngRxData,
      input  Grant, ReqDone, Nack, Error, RdData, EngCmd, EngGo, EngTxData, EngAbort
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with the current owner and the last-served pointer.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       Reset,
   input  logic [1:0] req,
   input  logic       grant_en,
   input  logic       finish_en,
   output logic [1:0] pick_c,
   output logic       owner_q
);
   logic last_q, last_d, owner_d;

   // On contention the client not served last wins.
   always_comb begin
      pick_c = req;
      if (req == 2'b11) pick_c = last_q ? 2'b01 : 2'b10;
   end

   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      if (grant_en)  owner_d = pick_c[1];
      if (finish_en) last_d  = owner_q;
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: rtl/i2c_bus_sequencer.sv
// Round-robin sharing of one I2C byte engine between two clients: START, address, data, STOP.
module i2c_bus_sequencer
   import i2c_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned TW      = 10
) (
   input logic                 clock,
   input logic                 Reset,
   i2c_bus_sequencer_if.master bus
);
   state_e            state_q, state_d;
   logic              issue_q, issue_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [N_CLI-1:0]  grant_q, grant_d, done_q, done_d;
   logic              nack_q, nack_d, error_q, error_d;
   logic              go_q, go_d, abort_q, abort_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, txd_q, txd_d;
   eng_cmd_e          cmd_q, cmd_d;
   logic [N_CLI-1:0]  pick_c, owner_oh_c;
   logic              owner_q, grant_en_c, finish_en_c;

   rr_arbiter2 u_arb (
      .clock     (clock),
      .Reset     (Reset),
      .req       (bus.Req),
      .grant_en  (grant_en_c),
      .finish_en (finish_en_c),
      .pick_c    (pick_c),
      .owner_q   (owner_q)
   );

   assign owner_oh_c = owner_q ? 2'b10 : 2'b01;

   // issue_q marks the first cycle in a command state, where EngGo is raised; afterwards we wait.
   always_comb begin
      state_d     = state_q;
      issue_d     = 1'b0;
      cnt_d       = cnt_q;
      req_d       = req_q;
      grant_d     = (state_q == S_IDLE) ? '0 : owner_oh_c;
      done_d      = '0;
      nack_d      = nack_q;
      error_d     = error_q;
      rdata_d     = rdata_q;
      cmd_d       = cmd_q;
      go_d        = 1'b0;
      txd_d       = txd_q;
      abort_d     = 1'b0;
      grant_en_c  = 1'b0;
      finish_en_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|bus.Req) begin
               grant_en_c = 1'b1;
               req_d      = (pick_c == 2'b10) ? {bus.Addr1, bus.RW[1], bus.WrData1}
                                              : {bus.Addr0, bus.RW[0], bus.WrData0};
               nack_d     = 1'b0;
               error_d    = 1'b0;
               issue_d    = 1'b1;
               state_d    = S_START;
            end
         end
         S_FINISH: begin
            done_d      = owner_oh_c;
            finish_en_c = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            if (issue_q) begin
               go_d  = 1'b1;
               cnt_d = '0;
               case (state_q)
                  S_START: cmd_d = CMD_START;
                  S_ADDR: begin
                     cmd_d = CMD_WRITE;
                     txd_d = {req_q.addr, req_q.rw};
                  end
                  S_DATA: begin
                     cmd_d = req_q.rw ? CMD_READ : CMD_WRITE;
                     if (!req_q.rw) txd_d = req_q.wdata;
                  end
                  default: cmd_d = CMD_STOP;
               endcase
            end else if (bus.EngDone) begin
               issue_d = 1'b1;
               case (state_q)
                  S_START: state_d = S_ADDR;
                  S_ADDR: begin
                     if (bus.EngAck == ACK) begin
                        state_d = S_DATA;
                     end else begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                     end
                  end
                  S_DATA: begin
                     state_d = S_STOP;
                     if (req_q.rw) rdata_d = bus.EngRxData;
                     else if (bus.EngAck != ACK) nack_d = 1'b1;
                  end
                  default: begin
                     issue_d = 1'b0;
                     state_d = S_FINISH;
                  end
               endcase
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               // Abort skips STOP; the engine releases the bus itself.
               abort_d = 1'b1;
               error_d = 1'b1;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         issue_q <= 1'b0;
         cnt_q   <= '0;
         req_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         nack_q  <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
         cmd_q   <= CMD_START;
         go_q    <= 1'b0;
         txd_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         nack_q  <= nack_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
         cmd_q   <= cmd_d;
         go_q    <= go_d;
         txd_q   <= txd_d;
         abort_q <= abort_d;
      end
   end

   assign bus.Grant     = grant_q;
   assign bus.ReqDone   = done_q;
   assign bus.Nack      = nack_q;
   assign bus.Error     = error_q;
   assign bus.RdData    = rdata_q;
   assign bus.EngCmd    = cmd_q;
   assign bus.EngGo     = go_q;
   assign bus.EngTxData = txd_q;
   assign bus.EngAbort  = abort_q;

endmodule

// File: tb/tb_i2c_bus_sequencer.sv
// Bench for i2c_bus_sequencer: behavioural I2C engine, transaction-level expectations per request.
module tb_i2c_bus_sequencer;
   import i2c_pkg::*;

   localparam int unsigned TIMEOUT = 1023;
   localparam int unsigned TW      = 10;

   logic        clock = 1'b0;
   logic        Reset = 1'b1;
   int unsigned cyc   = 0;
   int          n_cmp = 0;
   int          n_mis = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   i2c_bus_sequencer_if bus ();

   i2c_bus_sequencer #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clock (clock),
      .Reset (Reset),
      .bus   (bus.master)
   );

   // engine behaviour knobs and observation
   bit         eng_hang      = 1'b0;
   int         eng_lat       = 1;
   logic       cfg_addr_nack = 1'b0;
   logic       cfg_data_nack = 1'b0;
   logic [7:0] cfg_rx        = 8'h00;
   logic [9:0] cmd_log [$];
   logic [9:0] exp_log [$];
   logic       exp_nack;
   logic       model_last    = 1'b1;
   logic [1:0] obs_done;
   logic       obs_nack, obs_err;
   logic [7:0] obs_rd;

   // Behavioural byte engine: logs every command, answers after eng_lat idle cycles.
   initial begin
      int         wait_cnt;
      bit         busy;
      int         wr_idx;
      logic [1:0] pend;
      bus.EngDone = 1'b0; bus.EngAck = 1'b0; bus.EngRxData = 8'h00;
      busy = 0; wait_cnt = 0; wr_idx = 0; pend = 2'b00;
      forever begin
         @(negedge clock);
         bus.EngDone = 1'b0;
         if (Reset || bus.EngAbort) begin
            busy = 0;
         end else if (busy) begin
            if (wait_cnt == 0) begin
               bus.EngDone   = 1'b1;
               busy          = 0;
               bus.EngAck    = (pend == 2'(CMD_WRITE)) ? ((wr_idx == 1) ? cfg_addr_nack : cfg_data_nack) : 1'b0;
               bus.EngRxData = (pend == 2'(CMD_READ)) ? cfg_rx : 8'($urandom);
            end else begin
               wait_cnt--;
            end
         end
         if (!Reset && bus.EngGo) begin
            cmd_log.push_back({bus.EngCmd, bus.EngTxData});
            pend = bus.EngCmd;
            if (bus.EngCmd == CMD_START) wr_idx = 0;
            if (bus.EngCmd == CMD_WRITE) wr_idx++;
            busy     = !eng_hang;
            wait_cnt = eng_lat;
         end
      end
   end

   function automatic logic [9:0] log_key(input logic [9:0] e);
      return (e[9:8] == 2'(CMD_WRITE)) ? e : {e[9:8], 8'h00};
   endfunction

   // Expected engine command stream and NACK outcome of one request.
   function automatic void model_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                     input logic addr_nack, input logic data_nack);
      exp_log.delete();
      exp_log.push_back({CMD_START, 8'h00});
      exp_log.push_back({CMD_WRITE, a, rw});
      if (!addr_nack) exp_log.push_back(rw ? {CMD_READ, 8'h00} : {CMD_WRITE, wd});
      exp_log.push_back({CMD_STOP, 8'h00});
      exp_nack = addr_nack || (!rw && data_nack);
   endfunction

   task automatic apply_reset();
      Reset = 1'b1;
      bus.Req = 2'b00;
      repeat (3) @(negedge clock);
      Reset = 1'b0;
      model_last = 1'b1;
      cmd_log.delete();
   endtask

   task automatic do_txn(input logic [1:0] mask, output logic [1:0] done, output bit to);
      int n;
      bus.Req = mask; done = 2'b00; to = 1; n = 0;
      while (n < 4000 && to) begin
         @(negedge clock);
         n++;
         if (bus.ReqDone != 2'b00) begin
            done = bus.ReqDone; obs_nack = bus.Nack; obs_err = bus.Error; obs_rd = bus.RdData;
            to = 0;
            bus.Req = 2'b00;
         end
      end
      bus.Req = 2'b00;
      obs_done = done;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({bus.Grant, bus.ReqDone, bus.Nack, bus.Error, bus.EngGo, bus.EngAbort} !== 8'h00) begin
         n_mis++;
         $display("FAIL reset_ctrl: got %b required 00000000",
                  {bus.Grant, bus.ReqDone, bus.Nack, bus.Error, bus.EngGo, bus.EngAbort});
      end
      n_cmp++;
      if ({bus.RdData, bus.EngTxData, bus.EngCmd} !== 18'h0) begin
         n_mis++;
         $display("FAIL reset_data: got %h required 00000", {bus.RdData, bus.EngTxData, bus.EngCmd});
      end
   endtask

   task automatic test_write();
      logic [1:0] done;
      bit         to;
      bus.Addr0 = 7'h48; bus.RW = 2'b00; bus.WrData0 = 8'hA5;
      cfg_addr_nack = 1'b0; cfg_data_nack = 1'b0; eng_lat = 1;
      model_txn(7'h48, 1'b0, 8'hA5, 1'b0, 1'b0);
      @(negedge clock);
      cmd_log.delete();
      bus.Req = 2'b01;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({bus.Grant, bus.EngGo, bus.EngCmd} !== {2'b01, 1'b1, CMD_START}) begin
         n_mis++;
         $display("FAIL write_grant_latency: got %b required 01100", {bus.Grant, bus.EngGo, bus.EngCmd});
      end
      do_txn(2'b01, done, to);
      n_cmp++;
      if (to || done !== 2'b01 || obs_nack !== 1'b0 || obs_err !== 1'b0) begin
         n_mis++;
         $display("FAIL write_done: got to=%0d done=%b nack=%b err=%b required to=0 done=01 nack=0 err=0",
                  to, done, obs_nack, obs_err);
      end
      n_cmp++;
      if (bus.Grant !== 2'b01) begin
         n_mis++; $display("FAIL write_grant_hold: got %b required 01", bus.Grant);
      end
      @(negedge clock);
      n_cmp++;
      if (bus.Grant !== 2'b00) begin
         n_mis++; $display("FAIL write_grant_release: got %b required 00", bus.Grant);
      end
      n_cmp++;
      if (cmd_log.size() != exp_log.size()) begin
         n_mis++; $display("FAIL write_cmd_count: got %0d required %0d", cmd_log.size(), exp_log.size());
      end
      foreach (exp_log[i]) if (i < cmd_log.size()) begin
         n_cmp++;
         if (log_key(cmd_log[i]) !== exp_log[i]) begin
            n_mis++; $display("FAIL write_cmd[%0d]: got %h required %h", i, log_key(cmd_log[i]), exp_log[i]);
         end
      end
      model_last = 1'b0;
   endtask

   task automatic test_read();
      logic [1:0] done;
      bit         to;
      bus.Addr1 = 7'h1D; bus.RW = 2'b10; cfg_rx = 8'h3C; eng_lat = 2;
      model_txn(7'h1D, 1'b1, bus.WrData1, 1'b0, 1'b0);
      @(negedge clock);
      cmd_log.delete();
      do_txn(2'b10, done, to);
      n_cmp++;
      if (to || done !== 2'b10 || obs_nack !== 1'b0 || obs_rd !== 8'h3C) begin
         n_mis++;
         $display("FAIL read_done: got to=%0d done=%b nack=%b rd=%h required to=0 done=10 nack=0 rd=3c",
                  to, done, obs_nack, obs_rd);
      end
      n_cmp++;
      if (cmd_log.size() != exp_log.size()) begin
         n_mis++; $display("FAIL read_cmd_count: got %0d required %0d", cmd_log.size(), exp_log.size());
      end
      foreach (exp_log[i]) if (i < cmd_log.size()) begin
         n_cmp++;
         if (log_key(cmd_log[i]) !== exp_log[i]) begin
            n_mis++; $display("FAIL read_cmd[%0d]: got %h required %h", i, log_key(cmd_log[i]), exp_log[i]);
         end
      end
      model_last = 1'b1;
   endtask

   task automatic test_addr_nack();
      logic [1:0] done;
      bit         to;
      bus.Addr0 = 7'h22; bus.RW = 2'b00; bus.WrData0 = 8'h5A;
      cfg_addr_nack = 1'b1; cfg_data_nack = 1'b0; eng_lat = 0;
      model_txn(7'h22, 1'b0, 8'h5A, 1'b1, 1'b0);
      @(negedge clock);
      cmd_log.delete();
      do_txn(2'b01, done, to);
      cfg_addr_nack = 1'b0;
      n_cmp++;
      if (to || done !== 2'b01 || obs_nack !== 1'b1 || obs_err !== 1'b0) begin
         n_mis++;
         $display("FAIL nack_done: got to=%0d done=%b nack=%b err=%b required to=0 done=01 nack=1 err=0",
                  to, done, obs_nack, obs_err);
      end
      n_cmp++;
      if (cmd_log.size() != exp_log.size()) begin
         n_mis++; $display("FAIL nack_cmd_count: got %0d required %0d", cmd_log.size(), exp_log.size());
      end
      foreach (exp_log[i]) if (i < cmd_log.size()) begin
         n_cmp++;
         if (log_key(cmd_log[i]) !== exp_log[i]) begin
            n_mis++; $display("FAIL nack_cmd[%0d]: got %h required %h", i, log_key(cmd_log[i]), exp_log[i]);
         end
      end
      model_last = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0] done, mask;
      bit         to;
      logic       own, a_n, d_n;
      for (int it = 0; it < 24; it++) begin
         mask = 2'($urandom_range(1, 3));
         bus.Addr0 = 7'($urandom); bus.Addr1 = 7'($urandom);
         bus.WrData0 = 8'($urandom); bus.WrData1 = 8'($urandom);
         bus.RW = 2'($urandom);
         a_n = ($urandom_range(0, 3) == 0); d_n = ($urandom_range(0, 3) == 0);
         cfg_addr_nack = a_n; cfg_data_nack = d_n;
         cfg_rx = 8'($urandom); eng_lat = $urandom_range(0, 3);
         own = (mask == 2'b11) ? ~model_last : mask[1];
         model_txn(own ? bus.Addr1 : bus.Addr0, bus.RW[own], own ? bus.WrData1 : bus.WrData0, a_n, d_n);
         repeat (2) @(negedge clock);
         cmd_log.delete();
         do_txn(mask, done, to);
         n_cmp++;
         if (to || done !== (own ? 2'b10 : 2'b01) || obs_nack !== exp_nack || obs_err !== 1'b0) begin
            n_mis++;
            $display("FAIL rand%0d_done: got to=%0d done=%b nack=%b err=%b required to=0 done=%b nack=%b err=0",
                     it, to, done, obs_nack, obs_err, own ? 2'b10 : 2'b01, exp_nack);
         end
         if (bus.RW[own] && !a_n) begin
            n_cmp++;
            if (obs_rd !== cfg_rx) begin
               n_mis++; $display("FAIL rand%0d_rddata: got %h required %h", it, obs_rd, cfg_rx);
            end
         end
         n_cmp++;
         if (cmd_log.size() != exp_log.size()) begin
            n_mis++; $display("FAIL rand%0d_cmd_count: got %0d required %0d", it, cmd_log.size(), exp_log.size());
         end
         foreach (exp_log[i]) if (i < cmd_log.size()) begin
            n_cmp++;
            if (log_key(cmd_log[i]) !== exp_log[i]) begin
               n_mis++;
               $display("FAIL rand%0d_cmd[%0d]: got %h required %h", it, i, log_key(cmd_log[i]), exp_log[i]);
            end
         end
         model_last = own;
      end
      cfg_addr_nack = 1'b0; cfg_data_nack = 1'b0;
   endtask

   task automatic test_simultaneous();
      logic [1:0] seq [$];
      logic [1:0] exp_seq [6];
      int         dones, n;
      exp_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      bus.RW = 2'b00; eng_lat = 0;
      Reset = 1'b1; bus.Req = 2'b11;
      repeat (2) @(negedge clock);
      Reset = 1'b0;
      cmd_log.delete();
      dones = 0; n = 0;
      seq.push_back(bus.Grant);
      while (dones < 3 && n < 3000) begin
         @(negedge clock);
         n++;
         if (bus.Grant !== seq[$]) seq.push_back(bus.Grant);
         if (bus.ReqDone != 2'b00) dones++;
         bus.Req = (dones >= 3) ? 2'b00 : (2'b11 & ~bus.ReqDone);
      end
      bus.Req = 2'b00;
      n_cmp++;
      if (dones != 3 || seq.size() < 6) begin
         n_mis++; $display("FAIL rr_progress: got dones=%0d changes=%0d required 3 and >=6", dones, seq.size());
      end
      for (int i = 0; i < 6 && i < seq.size(); i++) begin
         n_cmp++;
         if (seq[i] !== exp_seq[i]) begin
            n_mis++; $display("FAIL rr_grant_seq[%0d]: got %b required %b", i, seq[i], exp_seq[i]);
         end
      end
      model_last = 1'b0;
   endtask

   task automatic test_timeout();
      int unsigned t0, t1;
      int          n;
      bit          seen;
      t0 = 0; t1 = 0;
      eng_hang = 1'b1;
      @(negedge clock);
      cmd_log.delete();
      bus.Addr0 = 7'h50; bus.RW = 2'b00;
      bus.Req = 2'b01;
      seen = 0; n = 0;
      while (!seen && n < 20) begin
         @(negedge clock); n++;
         if (bus.EngGo) begin seen = 1; t0 = cyc; end
      end
      n_cmp++;
      if (!seen) begin n_mis++; $display("FAIL timeout_go: got no EngGo required EngGo"); end
      seen = 0; n = 0;
      while (!seen && n < 1100) begin
         @(negedge clock); n++;
         if (bus.EngAbort) begin seen = 1; t1 = cyc; end
      end
      n_cmp++;
      if (!seen || (t1 - t0) != TIMEOUT) begin
         n_mis++; $display("FAIL timeout_abort_delay: got seen=%0d delay=%0d required 1 and %0d", seen, t1 - t0, TIMEOUT);
      end
      seen = 0; n = 0;
      while (!seen && n < 10) begin
         @(negedge clock); n++;
         if (bus.ReqDone != 2'b00) begin
            seen = 1; obs_done = bus.ReqDone; obs_err = bus.Error;
            bus.Req = 2'b00;
         end
      end
      bus.Req = 2'b00;
      n_cmp++;
      if (!seen || obs_done !== 2'b01 || obs_err !== 1'b1) begin
         n_mis++; $display("FAIL timeout_done: got seen=%0d done=%b err=%b required 1 01 1", seen, obs_done, obs_err);
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (cmd_log.size() != 1) begin
         n_mis++; $display("FAIL timeout_no_stop: got %0d commands required 1 (START only)", cmd_log.size());
      end
      eng_hang = 1'b0;
      model_last = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] done;
      bit         to;
      int         n, stops;
      eng_lat = 4; cfg_addr_nack = 1'b0;
      bus.Addr0 = 7'h11; bus.RW = 2'b00; bus.WrData0 = 8'hC3;
      @(negedge clock);
      cmd_log.delete();
      bus.Req = 2'b01;
      n = 0;
      while (cmd_log.size() < 3 && n < 100) begin @(negedge clock); n++; end
      n_cmp++;
      if (cmd_log.size() < 3) begin
         n_mis++; $display("FAIL rstmid_reach_data: got %0d commands required 3", cmd_log.size());
      end
      Reset = 1'b1; bus.Req = 2'b00;
      @(negedge clock);
      n_cmp++;
      if ({bus.Grant, bus.EngGo} !== 3'b000) begin
         n_mis++; $display("FAIL rstmid_outputs: got %b required 000", {bus.Grant, bus.EngGo});
      end
      Reset = 1'b0;
      model_last = 1'b1;
      repeat (8) @(negedge clock);
      stops = 0;
      foreach (cmd_log[i]) if (cmd_log[i][9:8] == 2'(CMD_STOP)) stops++;
      n_cmp++;
      if (stops != 0) begin n_mis++; $display("FAIL rstmid_no_stop: got %0d STOPs required 0", stops); end
      eng_lat = 1;
      bus.Req = 2'b11;
      n = 0;
      while (bus.Grant === 2'b00 && n < 10) begin @(negedge clock); n++; end
      n_cmp++;
      if (bus.Grant !== 2'b01) begin n_mis++; $display("FAIL rstmid_regrant: got %b required 01", bus.Grant); end
      do_txn(2'b11, done, to);
      n_cmp++;
      if (to || done !== 2'b01) begin
         n_mis++; $display("FAIL rstmid_done: got to=%0d done=%b required to=0 done=01", to, done);
      end
   endtask

   initial begin
      bus.Req = 2'b00; bus.Addr0 = 7'h00; bus.Addr1 = 7'h00; bus.RW = 2'b00;
      bus.WrData0 = 8'h00; bus.WrData1 = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_addr_nack();
      test_random();
      test_simultaneous();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
